// File: rtl/axi4_pkg.sv
// Shared encodings for the AXI4 slave RAM: burst/response codes and FSM states.
package axi4_pkg;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10,
    BURST_RSVD  = 2'b11
  } burst_e;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  typedef enum logic [1:0] {
    W_IDLE,
    W_DATA,
    W_RESP
  } wr_state_e;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } rd_state_e;

endpackage

// File: rtl/axi4_slave_ram_if.sv
// AXI4 bus bundle between a master and the slave RAM.
interface axi4_slave_ram_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16,
    parameter int STRB_WIDTH = DATA_WIDTH / 8,
    parameter int ID_WIDTH   = 8
);
    logic [ID_WIDTH-1:0]   awid;
    logic [ADDR_WIDTH-1:0] awaddr;
    logic [7:0]            awlen;
    logic [2:0]            awsize;
    logic [1:0]            awburst;
    logic                  awlock;
    logic [3:0]            awcache;
    logic [2:0]            awprot;
    logic                  awvalid;
    logic                  awready;

    logic [DATA_WIDTH-1:0] wdata;
    logic [STRB_WIDTH-1:0] wstrb;
    logic                  wlast;
    logic                  wvalid;
    logic                  wready;

    logic [ID_WIDTH-1:0]   bid;
    logic [1:0]            bresp;
    logic                  bvalid;
    logic                  bready;

    logic [ID_WIDTH-1:0]   arid;
    logic [ADDR_WIDTH-1:0] araddr;
    logic [7:0]            arlen;
    logic [2:0]            arsize;
    logic [1:0]            arburst;
    logic                  arlock;
    logic [3:0]            arcache;
    logic [2:0]            arprot;
    logic                  arvalid;
    logic                  arready;

    logic [ID_WIDTH-1:0]   rid;
    logic [DATA_WIDTH-1:0] rdata;
    logic [1:0]            rresp;
    logic                  rlast;
    logic                  rvalid;
    logic                  rready;

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready,
        input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready
    );

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready,
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready
    );
endinterface

// File: rtl/axi4_burst_addr.sv
// Combinational AXI4 next-beat address: FIXED / INCR / WRAP, reserved burst as INCR.
module axi4_burst_addr
    import axi4_pkg::*;
#(
    parameter int ADDR_WIDTH = 16,
    parameter int STRB_WIDTH = 4
) (
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [7:0]            len,
    input  logic [2:0]            size,
    input  logic [1:0]            burst,
    output logic [ADDR_WIDTH-1:0] next_addr
);
    localparam int LSB = $clog2(STRB_WIDTH);
    // Wide enough for a 256-beat wrap block of the widest beat.
    localparam int XW  = ADDR_WIDTH + 16;

    logic [2:0]            eff_size;
    logic [XW-1:0]         step;
    logic [XW-1:0]         wrap_mask;
    logic [ADDR_WIDTH-1:0] aligned;
    logic [ADDR_WIDTH-1:0] incr;

    always_comb begin
        eff_size  = (size > 3'(LSB)) ? 3'(LSB) : size;
        step      = XW'(1) << eff_size;
        aligned   = addr & ~ADDR_WIDTH'(step - XW'(1));
        incr      = aligned + ADDR_WIDTH'(step);
        wrap_mask = ((XW'(len) + XW'(1)) << eff_size) - XW'(1);
        case (burst_e'(burst))
            BURST_FIXED: next_addr = addr;
            BURST_WRAP:  next_addr = (aligned & ~ADDR_WIDTH'(wrap_mask))
                                   | (incr & ADDR_WIDTH'(wrap_mask));
            default:     next_addr = incr;
        endcase
    end
endmodule

// File: rtl/axi4_slave_ram.sv
// AXI4 slave memory endpoint with independent burst write and read paths
// over a byte-strobed internal RAM.
module axi4_slave_ram
    import axi4_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16,
    parameter int STRB_WIDTH = DATA_WIDTH / 8,
    parameter int ID_WIDTH   = 8
) (
    input  logic             clk,
    input  logic             rst,
    axi4_slave_ram_if.slave  s_axi
);
    localparam int LSB   = $clog2(STRB_WIDTH);
    localparam int WIDXW = ADDR_WIDTH - LSB;
    localparam int DEPTH = 2 ** WIDXW;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Keeps the address channels closed for the first cycle after reset release.
    logic ready_en;

    wr_state_e             wr_state, wr_next;
    logic [ID_WIDTH-1:0]   wr_id;
    logic [ADDR_WIDTH-1:0] wr_addr, wr_nxt_addr;
    logic [7:0]            wr_len, wr_cnt;
    logic [2:0]            wr_size;
    logic [1:0]            wr_burst;
    logic                  aw_rdy, w_rdy, b_vld, aw_hs, w_hs;

    rd_state_e             rd_state, rd_next;
    logic [ID_WIDTH-1:0]   rd_id;
    logic [ADDR_WIDTH-1:0] rd_addr, rd_nxt_addr;
    logic [7:0]            rd_len, rd_cnt;
    logic [2:0]            rd_size;
    logic [1:0]            rd_burst;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  rlast_q, ar_rdy, r_vld, ar_hs, r_hs;

    logic unused_sigs;
    assign unused_sigs = ^{s_axi.awlock, s_axi.awcache, s_axi.awprot, s_axi.wlast,
                           s_axi.arlock, s_axi.arcache, s_axi.arprot};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) ready_en <= 1'b0;
        else     ready_en <= 1'b1;
    end

    axi4_burst_addr #(.ADDR_WIDTH(ADDR_WIDTH), .STRB_WIDTH(STRB_WIDTH)) u_wr_addr (
        .addr(wr_addr), .len(wr_len), .size(wr_size), .burst(wr_burst), .next_addr(wr_nxt_addr)
    );

    axi4_burst_addr #(.ADDR_WIDTH(ADDR_WIDTH), .STRB_WIDTH(STRB_WIDTH)) u_rd_addr (
        .addr(rd_addr), .len(rd_len), .size(rd_size), .burst(rd_burst), .next_addr(rd_nxt_addr)
    );

    // Write FSM
    always_ff @(posedge clk or posedge rst) begin
        if (rst) wr_state <= W_IDLE;
        else     wr_state <= wr_next;
    end

    always_comb begin
        wr_next = wr_state;
        aw_rdy  = 1'b0;
        w_rdy   = 1'b0;
        b_vld   = 1'b0;
        case (wr_state)
            W_IDLE: begin
                aw_rdy = ready_en;
                if (ready_en && s_axi.awvalid) wr_next = W_DATA;
            end
            W_DATA: begin
                w_rdy = 1'b1;
                if (s_axi.wvalid && wr_cnt == wr_len) wr_next = W_RESP;
            end
            W_RESP: begin
                b_vld = 1'b1;
                if (s_axi.bready) wr_next = W_IDLE;
            end
            default: wr_next = W_IDLE;
        endcase
    end

    assign aw_hs = aw_rdy && s_axi.awvalid;
    assign w_hs  = w_rdy && s_axi.wvalid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_id    <= '0;
            wr_addr  <= '0;
            wr_len   <= '0;
            wr_size  <= '0;
            wr_burst <= '0;
            wr_cnt   <= '0;
        end else if (aw_hs) begin
            wr_id    <= s_axi.awid;
            wr_addr  <= s_axi.awaddr;
            wr_len   <= s_axi.awlen;
            wr_size  <= s_axi.awsize;
            wr_burst <= s_axi.awburst;
            wr_cnt   <= '0;
        end else if (w_hs) begin
            wr_addr  <= wr_nxt_addr;
            wr_cnt   <= wr_cnt + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_hs) begin
            for (int i = 0; i < STRB_WIDTH; i++)
                if (s_axi.wstrb[i])
                    mem[wr_addr[ADDR_WIDTH-1:LSB]][i*8 +: 8] <= s_axi.wdata[i*8 +: 8];
        end
    end

    // Read FSM
    always_ff @(posedge clk or posedge rst) begin
        if (rst) rd_state <= R_IDLE;
        else     rd_state <= rd_next;
    end

    always_comb begin
        rd_next = rd_state;
        ar_rdy  = 1'b0;
        r_vld   = 1'b0;
        case (rd_state)
            R_IDLE: begin
                ar_rdy = ready_en;
                if (ready_en && s_axi.arvalid) rd_next = R_DATA;
            end
            R_DATA: begin
                r_vld = 1'b1;
                if (s_axi.rready && rlast_q) rd_next = R_IDLE;
            end
            default: rd_next = R_IDLE;
        endcase
    end

    assign ar_hs = ar_rdy && s_axi.arvalid;
    assign r_hs  = r_vld && s_axi.rready;

    // rdata is fetched one beat ahead so it stays put through rready stalls
    // and sees pre-write contents on a same-cycle write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_id    <= '0;
            rd_addr  <= '0;
            rd_len   <= '0;
            rd_size  <= '0;
            rd_burst <= '0;
            rd_cnt   <= '0;
            rdata_q  <= '0;
            rlast_q  <= 1'b0;
        end else if (ar_hs) begin
            rd_id    <= s_axi.arid;
            rd_addr  <= s_axi.araddr;
            rd_len   <= s_axi.arlen;
            rd_size  <= s_axi.arsize;
            rd_burst <= s_axi.arburst;
            rd_cnt   <= '0;
            rdata_q  <= mem[s_axi.araddr[ADDR_WIDTH-1:LSB]];
            rlast_q  <= (s_axi.arlen == 8'd0);
        end else if (r_hs) begin
            if (rlast_q) begin
                rlast_q <= 1'b0;
            end else begin
                rd_addr <= rd_nxt_addr;
                rd_cnt  <= rd_cnt + 8'd1;
                rdata_q <= mem[rd_nxt_addr[ADDR_WIDTH-1:LSB]];
                rlast_q <= (rd_cnt + 8'd1 == rd_len);
            end
        end
    end

    assign s_axi.awready = aw_rdy;
    assign s_axi.wready  = w_rdy;
    assign s_axi.bvalid  = b_vld;
    assign s_axi.bid     = wr_id;
    assign s_axi.bresp   = RESP_OKAY;
    assign s_axi.arready = ar_rdy;
    assign s_axi.rvalid  = r_vld;
    assign s_axi.rid     = rd_id;
    assign s_axi.rdata   = rdata_q;
    assign s_axi.rresp   = RESP_OKAY;
    assign s_axi.rlast   = rlast_q;
endmodule

// File: tb/tb_axi4_slave_ram.sv
// Randomized bench for axi4_slave_ram against a byte-level memory model and
// an address-sequence model built from burst arithmetic.
module tb_axi4_slave_ram;
    import axi4_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    axi4_slave_ram_if bus ();
    axi4_slave_ram dut (.clk(clk), .rst(rst), .s_axi(bus));

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [31:0] data;
        logic [31:0] mask;
        logic [7:0]  id;
        logic        last;
    } rexp_t;

    rexp_t       exp_r[$];
    logic [7:0]  exp_b[$];
    logic [31:0] mdata  [16384];
    logic [3:0]  mknown [16384];
    logic [31:0] wdat [256];
    logic [3:0]  wstb [256];
    logic [31:0] cap_d [256];
    logic        cap_l [256];
    int          cap_n;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tmo(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out at %0t", name, $time);
    endtask

    // Byte address of beat k from the burst rules, independent of the RTL.
    function automatic int unsigned beat_addr(input int unsigned a, input int len,
                                              input int size, input int burst, input int k);
        int unsigned n, al, wb, base;
        n  = 1 << ((size > 2) ? 2 : size);
        if (k == 0 || burst == 0) return a & 32'hFFFF;
        al = a - (a % n);
        if (burst == 2) begin
            wb   = (len + 1) * n;
            base = al - (al % wb);
            return (base + ((al - base + k * n) % wb)) & 32'hFFFF;
        end
        return (al + k * n) & 32'hFFFF;
    endfunction

    // Per-cycle checker of B and R channels against expectation queues.
    logic        pb_hold, pr_hold;
    logic [31:0] p_rdata;
    logic [7:0]  p_rid;
    logic        p_rlast;

    always @(negedge clk) begin
        if (rst) begin
            chk("rst_bvalid",  bus.bvalid,  0);
            chk("rst_rvalid",  bus.rvalid,  0);
            chk("rst_awready", bus.awready, 0);
            chk("rst_arready", bus.arready, 0);
            chk("rst_wready",  bus.wready,  0);
            pb_hold <= 1'b0;
            pr_hold <= 1'b0;
        end else begin
            if (pb_hold) chk("bvalid_held", bus.bvalid, 1);
            if (bus.bvalid) begin
                if (exp_b.size() == 0) chk("b_unexpected", bus.bvalid, 0);
                else begin
                    chk("bid", bus.bid, exp_b[0]);
                    chk("bresp", bus.bresp, 0);
                    chk("aw_blocked", bus.awready, 0);
                    if (bus.bready) void'(exp_b.pop_front());
                end
            end
            if (pr_hold) begin
                chk("rvalid_held", bus.rvalid, 1);
                chk("rdata_stable", bus.rdata, p_rdata);
                chk("rid_stable", bus.rid, p_rid);
                chk("rlast_stable", bus.rlast, p_rlast);
            end
            if (bus.rvalid) begin
                if (exp_r.size() == 0) chk("r_unexpected", bus.rvalid, 0);
                else begin
                    chk("rdata", bus.rdata & exp_r[0].mask, exp_r[0].data & exp_r[0].mask);
                    chk("rid", bus.rid, exp_r[0].id);
                    chk("rlast", bus.rlast, exp_r[0].last);
                    chk("rresp", bus.rresp, 0);
                    if (bus.rready) void'(exp_r.pop_front());
                end
            end
            pb_hold <= bus.bvalid && !bus.bready;
            pr_hold <= bus.rvalid && !bus.rready;
            p_rdata <= bus.rdata;
            p_rid   <= bus.rid;
            p_rlast <= bus.rlast;
        end
    end

    task automatic do_write(input logic [7:0] id, input logic [15:0] addr, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst,
                            input int bdelay, input bit abort2);
        int to;
        int unsigned a, w;
        @(posedge clk); #1;
        bus.awid = id; bus.awaddr = addr; bus.awlen = len; bus.awsize = size;
        bus.awburst = burst; bus.awlock = 1'($urandom); bus.awcache = 4'($urandom);
        bus.awprot = 3'($urandom); bus.awvalid = 1'b1;
        to = 0;
        @(negedge clk);
        while (!bus.awready && to < 200) begin to++; @(negedge clk); end
        if (to >= 200) begin tmo("aw_handshake"); bus.awvalid = 1'b0; return; end
        @(posedge clk); #1;
        bus.awvalid = 1'b0;
        for (int k = 0; k <= int'(len); k++) begin
            if (abort2 && k == 2) begin
                rst = 1'b1; bus.wvalid = 1'b0;
                @(posedge clk); #1; @(posedge clk); #1;
                rst = 1'b0;
                return;
            end
            if ($urandom % 4 == 0) begin bus.wvalid = 1'b0; @(posedge clk); #1; end
            bus.wvalid = 1'b1; bus.wdata = wdat[k]; bus.wstrb = wstb[k];
            bus.wlast = (k == int'(len));
            to = 0;
            @(negedge clk);
            while (!bus.wready && to < 200) begin to++; @(negedge clk); end
            if (to >= 200) begin tmo("w_handshake"); bus.wvalid = 1'b0; return; end
            a = beat_addr(addr, len, size, burst, k);
            w = (a >> 2) & 16383;
            for (int b = 0; b < 4; b++)
                if (wstb[k][b]) begin
                    mdata[w][8*b +: 8] = wdat[k][8*b +: 8];
                    mknown[w][b] = 1'b1;
                end
            @(posedge clk); #1;
        end
        bus.wvalid = 1'b0; bus.wlast = 1'b0;
        exp_b.push_back(id);
        bus.bready = 1'b0;
        for (int i = 0; i < bdelay; i++) begin @(posedge clk); #1; end
        bus.bready = 1'b1;
        to = 0;
        while (exp_b.size() != 0 && to < 200) begin @(posedge clk); #1; to++; end
        if (to >= 200) begin tmo("b_handshake"); exp_b.delete(); end
        bus.bready = 1'b0;
    endtask

    // mode: 0 always ready, 1 random ready, 2 five-cycle stall on beat 1
    task automatic do_read(input logic [7:0] id, input logic [15:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst, input int mode);
        int to, cyc;
        int unsigned a, w;
        rexp_t e;
        @(posedge clk); #1;
        bus.arid = id; bus.araddr = addr; bus.arlen = len; bus.arsize = size;
        bus.arburst = burst; bus.arlock = 1'($urandom); bus.arcache = 4'($urandom);
        bus.arprot = 3'($urandom); bus.arvalid = 1'b1;
        to = 0;
        @(negedge clk);
        while (!bus.arready && to < 200) begin to++; @(negedge clk); end
        if (to >= 200) begin tmo("ar_handshake"); bus.arvalid = 1'b0; return; end
        @(posedge clk); #1;
        bus.arvalid = 1'b0;
        for (int k = 0; k <= int'(len); k++) begin
            a = beat_addr(addr, len, size, burst, k);
            w = (a >> 2) & 16383;
            e.data = mdata[w];
            e.mask = '0;
            for (int b = 0; b < 4; b++) if (mknown[w][b]) e.mask[8*b +: 8] = 8'hFF;
            e.id = id;
            e.last = (k == int'(len));
            exp_r.push_back(e);
        end
        cap_n = 0; cyc = 0; to = 0;
        while (cap_n <= int'(len) && to < 2000) begin
            case (mode)
                0:       bus.rready = 1'b1;
                1:       bus.rready = 1'($urandom);
                default: bus.rready = !(cyc >= 1 && cyc <= 5);
            endcase
            @(negedge clk);
            if (bus.rvalid && bus.rready) begin
                cap_d[cap_n] = bus.rdata; cap_l[cap_n] = bus.rlast; cap_n++;
            end
            @(posedge clk); #1;
            cyc++; to++;
        end
        bus.rready = 1'b0;
        if (to >= 2000) begin tmo("r_burst"); exp_r.delete(); end
    endtask

    logic [31:0] lit4 [4];
    logic [15:0] waddr4 [4];

    initial begin
        bus.awvalid = 0; bus.wvalid = 0; bus.bready = 0; bus.arvalid = 0; bus.rready = 0;
        bus.awid = 0; bus.awaddr = 0; bus.awlen = 0; bus.awsize = 0; bus.awburst = 0;
        bus.awlock = 0; bus.awcache = 0; bus.awprot = 0; bus.wdata = 0; bus.wstrb = 0;
        bus.wlast = 0; bus.arid = 0; bus.araddr = 0; bus.arlen = 0; bus.arsize = 0;
        bus.arburst = 0; bus.arlock = 0; bus.arcache = 0; bus.arprot = 0;
        for (int i = 0; i < 16384; i++) begin mdata[i] = '0; mknown[i] = '0; end

        // Reset state and release
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_rdata", bus.rdata, 0);
        chk("reset_rlast", bus.rlast, 0);
        chk("reset_bid", bus.bid, 0);
        chk("reset_rid", bus.rid, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("awready_before_edge", bus.awready, 0);
        @(negedge clk);
        chk("awready_after_release", bus.awready, 1);
        chk("arready_after_release", bus.arready, 1);

        // INCR write/read
        for (int k = 0; k < 4; k++) begin wdat[k] = 32'hA0 + k; wstb[k] = 4'hF; end
        do_write(8'h5A, 16'h0010, 8'd3, 3'd2, 2'd1, 0, 0);
        do_read(8'h33, 16'h0010, 8'd3, 3'd2, 2'd1, 0);
        chk("incr_beats", cap_n, 4);
        for (int k = 0; k < 4; k++) begin
            chk("incr_rdata_lit", cap_d[k], 32'hA0 + k);
            chk("incr_rlast_lit", cap_l[k], (k == 3) ? 1 : 0);
        end

        // Partial strobe merge
        wdat[0] = 32'h11223344; wstb[0] = 4'hF;
        do_write(8'h01, 16'h0020, 8'd0, 3'd2, 2'd1, 0, 0);
        wdat[0] = 32'hAABBCCDD; wstb[0] = 4'b0101;
        do_write(8'h02, 16'h0020, 8'd0, 3'd2, 2'd1, 1, 0);
        do_read(8'h03, 16'h0020, 8'd0, 3'd2, 2'd1, 0);
        chk("strobe_merge_lit", cap_d[0], 32'h11BB33DD);

        // WRAP read
        for (int k = 0; k < 4; k++) begin wdat[k] = 32'hC0DE0030 + 4 * k; wstb[k] = 4'hF; end
        do_write(8'h04, 16'h0030, 8'd3, 3'd2, 2'd1, 0, 0);
        waddr4[0] = 16'h38; waddr4[1] = 16'h3C; waddr4[2] = 16'h30; waddr4[3] = 16'h34;
        for (int k = 0; k < 4; k++)
            chk("wrap_model_addr", beat_addr(32'h38, 3, 2, 2, k), {16'h0, waddr4[k]});
        do_read(8'h05, 16'h0038, 8'd3, 3'd2, 2'd2, 1);
        lit4[0] = 32'hC0DE0038; lit4[1] = 32'hC0DE003C; lit4[2] = 32'hC0DE0030; lit4[3] = 32'hC0DE0034;
        for (int k = 0; k < 4; k++) chk("wrap_rdata_lit", cap_d[k], lit4[k]);

        // Back-pressure on B and R
        for (int k = 0; k < 8; k++) begin wdat[k] = $urandom; wstb[k] = 4'hF; end
        do_write(8'h06, 16'h0200, 8'd7, 3'd2, 2'd1, 4, 0);
        do_read(8'h07, 16'h0200, 8'd7, 3'd2, 2'd1, 2);
        chk("stall_beats", cap_n, 8);

        // Reset mid-burst, then normal traffic
        for (int k = 0; k < 8; k++) begin wdat[k] = $urandom; wstb[k] = 4'hF; end
        do_write(8'h08, 16'h0300, 8'd7, 3'd2, 2'd1, 0, 1);
        repeat (3) @(posedge clk);
        for (int k = 0; k < 4; k++) begin wdat[k] = 32'h5500 + k; wstb[k] = 4'hF; end
        do_write(8'h09, 16'h0400, 8'd3, 3'd2, 2'd1, 0, 0);
        do_read(8'h0A, 16'h0400, 8'd3, 3'd2, 2'd1, 0);
        chk("post_reset_beat3_lit", cap_d[3], 32'h5503);
        do_read(8'h0B, 16'h0300, 8'd1, 3'd2, 2'd1, 0);

        // Concurrent write and read on disjoint regions
        for (int k = 0; k < 8; k++) begin wdat[k] = $urandom; wstb[k] = 4'hF; end
        fork
            do_write(8'h0C, 16'h1000, 8'd7, 3'd2, 2'd1, 1, 0);
            do_read(8'h0D, 16'h0200, 8'd7, 3'd2, 2'd1, 1);
        join

        // Address space wrap and a 256-beat burst
        for (int k = 0; k < 256; k++) begin wdat[k] = $urandom; wstb[k] = 4'($urandom); end
        do_write(8'h0E, 16'hFFF8, 8'd3, 3'd2, 2'd1, 0, 0);
        do_read(8'h0F, 16'hFFF8, 8'd3, 3'd2, 2'd1, 1);
        do_write(8'h10, 16'h2000, 8'd255, 3'd2, 2'd1, 0, 0);
        do_read(8'h11, 16'h2000, 8'd255, 3'd2, 2'd1, 1);

        // Random bursts, including narrow, clamped size, FIXED and reserved
        for (int t = 0; t < 40; t++) begin
            logic [7:0]  id, len;
            logic [15:0] addr;
            logic [2:0]  size;
            logic [1:0]  burst;
            id    = 8'($urandom);
            addr  = 16'($urandom);
            size  = 3'($urandom_range(0, 3));
            burst = 2'($urandom_range(0, 3));
            if (burst == 2'd2) len = 8'((2 << $urandom_range(0, 3)) - 1);
            else               len = 8'($urandom_range(0, 15));
            for (int k = 0; k <= int'(len); k++) begin wdat[k] = $urandom; wstb[k] = 4'($urandom); end
            do_write(id, addr, len, size, burst, $urandom_range(0, 2), 0);
            do_read(~id, addr, len, size, burst, 1);
        end

        repeat (5) @(posedge clk);
        chk("r_queue_drained", exp_r.size(), 0);
        chk("b_queue_drained", exp_b.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
